// File: rtl/qspi_dispatcher.sv
// QSPI front-end dispatcher: loads a key into NUM_ENC encrypters, then packs
// LANES-wide beats into ENC_WIDTH packets and hands them out with key rotation.
module qspi_dispatcher #(
    parameter int NUM_ENC     = 4,
    parameter int ENC_WIDTH   = 32,
    parameter int KEY_WIDTH   = 128,
    parameter int LANES       = 4,
    parameter int MODE        = 0,
    parameter int PAD_PARTIAL = 1,
    parameter int ROT_W       = $clog2(KEY_WIDTH)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [LANES-1:0]               qspi_data,
    input  logic                           qspi_sending,
    output logic                           qspi_ready,
    input  logic                           prog,
    output logic [NUM_ENC*ENC_WIDTH-1:0]   enc_data,
    output logic [NUM_ENC*ROT_W-1:0]       enc_key_rot,
    output logic [NUM_ENC-1:0]             enc_program,
    output logic [NUM_ENC-1:0]             enc_data_valid,
    input  logic [NUM_ENC-1:0]             enc_ready,
    output logic                           key_valid,
    output logic [2:0]                     state_out,
    output logic [$clog2(NUM_ENC)-1:0]     rr_ptr_out,
    output logic [15:0]                    packet_count
);

    localparam int BEATS_P = ENC_WIDTH / LANES;
    localparam int BEATS_K = KEY_WIDTH / LANES;
    localparam int WORDS_K = KEY_WIDTH / ENC_WIDTH;
    localparam int PTR_W   = $clog2(NUM_ENC);
    localparam int CNT_W   = $clog2(BEATS_K + 1);
    localparam int LIDX_W  = (WORDS_K > 1) ? $clog2(WORDS_K) : 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARMED    = 3'd1,
        S_RX_KEY   = 3'd2,
        S_LOAD     = 3'd3,
        S_WAIT_ENC = 3'd4,
        S_STREAM   = 3'd5,
        S_DISPATCH = 3'd6
    } state_t;

    state_t                       r_state, w_next;
    logic [KEY_WIDTH-1:0]         r_key;
    logic [ENC_WIDTH-1:0]         r_pkt;
    logic [CNT_W-1:0]             r_beat_cnt;
    logic [LIDX_W-1:0]            r_load_idx;
    logic                         r_key_valid;
    logic [PTR_W-1:0]             r_ptr;
    logic [ROT_W-1:0]             r_rot;
    logic [15:0]                  r_pkt_cnt;
    logic [NUM_ENC*ENC_WIDTH-1:0] r_enc_data;
    logic [NUM_ENC*ROT_W-1:0]     r_enc_rot;
    logic [NUM_ENC-1:0]           r_enc_valid;

    logic                         w_beat, w_pkt_last, w_key_last, w_load_last;
    logic                         w_tgt_ok, w_fire;
    logic [PTR_W-1:0]             w_tgt, w_cand;
    logic [ENC_WIDTH-1:0]         w_key_word;

    assign w_beat      = qspi_sending && qspi_ready;
    assign w_pkt_last  = (r_beat_cnt == CNT_W'(BEATS_P - 1));
    assign w_key_last  = (r_beat_cnt == CNT_W'(BEATS_K - 1));
    assign w_load_last = (r_load_idx == LIDX_W'(WORDS_K - 1));
    assign w_fire      = (r_state == S_DISPATCH) && w_tgt_ok;

    assign enc_key_rot    = r_enc_rot;
    assign enc_data_valid = r_enc_valid;
    assign key_valid      = r_key_valid;
    assign state_out      = r_state;
    assign rr_ptr_out     = r_ptr;
    assign packet_count   = r_pkt_cnt;

    // First-ready mode scans from the pointer so priority rotates with it.
    always_comb begin
        w_tgt    = r_ptr;
        w_cand   = r_ptr;
        w_tgt_ok = enc_ready[r_ptr];
        if (MODE == 1) begin
            w_tgt_ok = 1'b0;
            for (int unsigned i = 0; i < NUM_ENC; i++) begin
                w_cand = PTR_W'((32'(r_ptr) + i) % NUM_ENC);
                if (!w_tgt_ok && enc_ready[w_cand]) begin
                    w_tgt    = w_cand;
                    w_tgt_ok = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_key_word = '0;
        for (int unsigned j = 0; j < WORDS_K; j++) begin
            if (r_load_idx == LIDX_W'(j))
                w_key_word = r_key[j*ENC_WIDTH +: ENC_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (prog)        w_next = S_ARMED;
                else if (w_beat) w_next = (BEATS_P == 1) ? S_DISPATCH : S_STREAM;
            end
            S_ARMED: begin
                if (w_beat) w_next = (BEATS_K == 1) ? S_LOAD : S_RX_KEY;
            end
            S_RX_KEY: begin
                if (!w_beat)        w_next = S_IDLE;
                else if (w_key_last) w_next = S_LOAD;
            end
            S_LOAD: begin
                if (w_load_last) w_next = S_WAIT_ENC;
            end
            S_WAIT_ENC: begin
                if (&enc_ready) w_next = S_IDLE;
            end
            S_STREAM: begin
                if (w_beat) begin
                    if (w_pkt_last) w_next = S_DISPATCH;
                end else if (r_beat_cnt == '0 || PAD_PARTIAL == 0) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                if (w_tgt_ok) w_next = qspi_sending ? S_STREAM : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // During LOAD the key word bypasses the data register so it appears in
    // the same cycle; the register captures it so idle slices hold it after.
    always_comb begin
        qspi_ready  = 1'b0;
        enc_program = '0;
        enc_data    = r_enc_data;
        case (r_state)
            S_IDLE:                      qspi_ready = r_key_valid;
            S_ARMED, S_RX_KEY, S_STREAM: qspi_ready = 1'b1;
            S_LOAD: begin
                enc_program = '1;
                enc_data    = {NUM_ENC{w_key_word}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_key       <= '0;
            r_pkt       <= '0;
            r_beat_cnt  <= '0;
            r_load_idx  <= '0;
            r_key_valid <= 1'b0;
            r_ptr       <= '0;
            r_rot       <= '0;
            r_pkt_cnt   <= '0;
            r_enc_data  <= '0;
            r_enc_rot   <= '0;
            r_enc_valid <= '0;
        end else begin
            r_enc_valid <= '0;
            case (r_state)
                S_IDLE: begin
                    if (prog) begin
                        r_key_valid <= 1'b0;
                    end else if (w_beat) begin
                        r_pkt      <= ENC_WIDTH'(qspi_data);
                        r_beat_cnt <= (BEATS_P == 1) ? '0 : CNT_W'(1);
                        r_ptr      <= '0;
                        r_rot      <= '0;
                        r_pkt_cnt  <= '0;
                    end
                end
                S_ARMED: begin
                    if (w_beat) begin
                        r_key[LANES-1:0] <= qspi_data;
                        r_beat_cnt       <= (BEATS_K == 1) ? '0 : CNT_W'(1);
                        r_load_idx       <= '0;
                    end
                end
                S_RX_KEY: begin
                    if (w_beat) begin
                        for (int unsigned k = 0; k < BEATS_K; k++) begin
                            if (r_beat_cnt == CNT_W'(k))
                                r_key[k*LANES +: LANES] <= qspi_data;
                        end
                        r_beat_cnt <= w_key_last ? '0 : r_beat_cnt + 1'b1;
                    end else begin
                        r_beat_cnt <= '0;
                    end
                end
                S_LOAD: begin
                    r_enc_data <= {NUM_ENC{w_key_word}};
                    r_load_idx <= w_load_last ? '0 : r_load_idx + 1'b1;
                end
                S_WAIT_ENC: begin
                    if (&enc_ready) r_key_valid <= 1'b1;
                end
                S_STREAM: begin
                    if (w_beat) begin
                        for (int unsigned k = 0; k < BEATS_P; k++) begin
                            if (r_beat_cnt == CNT_W'(k))
                                r_pkt[k*LANES +: LANES] <= qspi_data;
                        end
                        r_beat_cnt <= w_pkt_last ? '0 : r_beat_cnt + 1'b1;
                    end else begin
                        // Unfilled bits are already zero, so padding needs no masking.
                        r_beat_cnt <= '0;
                        if (r_beat_cnt == '0 || PAD_PARTIAL == 0) r_pkt <= '0;
                    end
                end
                S_DISPATCH: begin
                    if (w_fire) begin
                        for (int unsigned c = 0; c < NUM_ENC; c++) begin
                            if (w_tgt == PTR_W'(c)) begin
                                r_enc_valid[c]                     <= 1'b1;
                                r_enc_data[c*ENC_WIDTH +: ENC_WIDTH] <= r_pkt;
                                r_enc_rot[c*ROT_W +: ROT_W]          <= r_rot;
                            end
                        end
                        r_ptr     <= (w_tgt == PTR_W'(NUM_ENC - 1)) ? '0 : w_tgt + 1'b1;
                        r_rot     <= (r_rot == ROT_W'(KEY_WIDTH - 1)) ? '0 : r_rot + 1'b1;
                        r_pkt_cnt <= r_pkt_cnt + 16'd1;
                        r_pkt     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_qspi_dispatcher.sv
// Scoreboard bench: two dispatchers (round-robin/pad and first-ready/discard)
// share stimulus; a negedge monitor checks every strobe against queued events.
module tb_qspi_dispatcher;

    localparam int NE = 4, EW = 8, KW = 16, LN = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  qspi_data = '0;
    logic        qspi_sending = 1'b0;
    logic        prog = 1'b0;
    logic [3:0]  enc_ready = '0;

    logic        rdy0, rdy1, kv0, kv1;
    logic [31:0] data0, data1;
    logic [15:0] rot0, rot1, cnt0, cnt1;
    logic [3:0]  pg0, pg1, vl0, vl1;
    logic [2:0]  st0, st1;
    logic [1:0]  ptr0, ptr1;

    always #5 clk = ~clk;

    qspi_dispatcher #(.NUM_ENC(NE), .ENC_WIDTH(EW), .KEY_WIDTH(KW), .LANES(LN),
                      .MODE(0), .PAD_PARTIAL(1)) dut0 (
        .clk(clk), .reset(reset), .qspi_data(qspi_data), .qspi_sending(qspi_sending),
        .qspi_ready(rdy0), .prog(prog), .enc_data(data0), .enc_key_rot(rot0),
        .enc_program(pg0), .enc_data_valid(vl0), .enc_ready(enc_ready),
        .key_valid(kv0), .state_out(st0), .rr_ptr_out(ptr0), .packet_count(cnt0));

    qspi_dispatcher #(.NUM_ENC(NE), .ENC_WIDTH(EW), .KEY_WIDTH(KW), .LANES(LN),
                      .MODE(1), .PAD_PARTIAL(0)) dut1 (
        .clk(clk), .reset(reset), .qspi_data(qspi_data), .qspi_sending(qspi_sending),
        .qspi_ready(rdy1), .prog(prog), .enc_data(data1), .enc_key_rot(rot1),
        .enc_program(pg1), .enc_data_valid(vl1), .enc_ready(enc_ready),
        .key_valid(kv1), .state_out(st1), .rr_ptr_out(ptr1), .packet_count(cnt1));

    typedef struct {
        bit         is_prog;
        int         ch;
        logic [7:0] data;
        logic [3:0] rot;
    } ev_t;

    ev_t        q0[$];
    ev_t        q1[$];
    logic [3:0] bq[$];
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_ev(input int d, input bit p, input int ch,
                           input logic [7:0] data, input logic [3:0] rot);
        ev_t e;
        e.is_prog = p; e.ch = ch; e.data = data; e.rot = rot;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic pop_ev(input int d, output ev_t e, output bit got);
        e = '{default: 0};
        got = 1'b0;
        if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
        if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
    endtask

    task automatic mon(input int d, input logic [3:0] pg, input logic [3:0] vl,
                       input logic [31:0] dat, input logic [15:0] rot);
        ev_t e;
        bit  got;
        if (pg != 4'h0) begin
            pop_ev(d, e, got);
            if (!got) begin
                n_checks++; n_fail++;
                $display("FAIL d%0d_prog_unexpected: got program=0x%0h expected none", d, pg);
            end else begin
                chk($sformatf("d%0d_kind_prog", d), 32'(e.is_prog), 32'd1);
                chk($sformatf("d%0d_prog_mask", d), 32'(pg), 32'hF);
                chk($sformatf("d%0d_prog_word", d), dat, {4{e.data}});
            end
        end
        for (int c = 0; c < NE; c++) begin
            if (vl[c]) begin
                pop_ev(d, e, got);
                if (!got) begin
                    n_checks++; n_fail++;
                    $display("FAIL d%0d_valid_unexpected: got valid on ch%0d data 0x%0h expected none",
                             d, c, dat[c*8 +: 8]);
                end else begin
                    chk($sformatf("d%0d_kind_pkt", d), 32'(e.is_prog), 32'd0);
                    chk($sformatf("d%0d_ch", d), 32'(c), 32'(e.ch));
                    chk($sformatf("d%0d_pkt_data", d), 32'(dat[c*8 +: 8]), 32'(e.data));
                    chk($sformatf("d%0d_pkt_rot", d), 32'(rot[c*4 +: 4]), 32'(e.rot));
                end
            end
        end
        if (pg != 4'h0 && vl != 4'h0) begin
            n_checks++; n_fail++;
            $display("FAIL d%0d_prog_valid_overlap: got program=0x%0h valid=0x%0h expected disjoint",
                     d, pg, vl);
        end
    endtask

    always @(negedge clk) begin
        mon(0, pg0, vl0, data0, rot0);
        mon(1, pg1, vl1, data1, rot1);
    end

    task automatic chk_zero(input int d, input logic rdy, input logic [3:0] pg,
                            input logic [3:0] vl, input logic [31:0] dat,
                            input logic [15:0] rot, input logic kv, input logic [2:0] st,
                            input logic [1:0] ptr, input logic [15:0] cnt);
        chk($sformatf("d%0d_rst_ready", d), 32'(rdy), 0);
        chk($sformatf("d%0d_rst_program", d), 32'(pg), 0);
        chk($sformatf("d%0d_rst_valid", d), 32'(vl), 0);
        chk($sformatf("d%0d_rst_data", d), dat, 0);
        chk($sformatf("d%0d_rst_rot", d), 32'(rot), 0);
        chk($sformatf("d%0d_rst_key_valid", d), 32'(kv), 0);
        chk($sformatf("d%0d_rst_state", d), 32'(st), 0);
        chk($sformatf("d%0d_rst_ptr", d), 32'(ptr), 0);
        chk($sformatf("d%0d_rst_count", d), 32'(cnt), 0);
    endtask

    task automatic chk_both_zero();
        chk_zero(0, rdy0, pg0, vl0, data0, rot0, kv0, st0, ptr0, cnt0);
        chk_zero(1, rdy1, pg1, vl1, data1, rot1, kv1, st1, ptr1, cnt1);
    endtask

    // Beats are handed over while dut0 reports ready; sending drops afterwards.
    task automatic send_burst();
        int guard;
        while (bq.size() > 0) begin
            @(negedge clk);
            qspi_sending = 1'b1;
            qspi_data    = bq[0];
            guard = 0;
            while (!rdy0 && guard < 40) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 40) begin
                n_checks++; n_fail++;
                $display("FAIL beat_timeout: got qspi_ready=0 for 40 cycles expected 1");
                bq.delete();
            end else begin
                @(posedge clk);
                void'(bq.pop_front());
            end
        end
        @(negedge clk);
        qspi_sending = 1'b0;
    endtask

    task automatic wait_idle();
        int g = 0;
        while ((st0 != 3'd0 || st1 != 3'd0) && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("wait_idle_st0", 32'(st0), 0);
        chk("wait_idle_st1", 32'(st1), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g;
        logic [7:0] dv;

        repeat (2) @(negedge clk);
        chk_both_zero();
        reset = 1'b0;

        // Key programming with encrypters busy until after LOAD
        @(negedge clk); prog = 1'b1;
        @(negedge clk); prog = 1'b0;
        chk("armed_st0", 32'(st0), 1);
        chk("armed_st1", 32'(st1), 1);
        chk("armed_ready", 32'(rdy0), 1);
        for (int d = 0; d < 2; d++) begin
            push_ev(d, 1'b1, 0, 8'h21, 4'h0);
            push_ev(d, 1'b1, 0, 8'h43, 4'h0);
        end
        bq.push_back(4'h1); bq.push_back(4'h2); bq.push_back(4'h3); bq.push_back(4'h4);
        send_burst();
        g = 0;
        while (st0 != 3'd4 && g < 10) begin @(negedge clk); g++; end
        chk("wait_enc_st0", 32'(st0), 4);
        chk("wait_enc_prog0", 32'(pg0), 0);
        @(negedge clk);
        chk("wait_enc_hold_kv0", 32'(kv0), 0);
        enc_ready = 4'hF;
        g = 0;
        while (!(kv0 && kv1) && g < 10) begin @(negedge clk); g++; end
        chk("key_valid0", 32'(kv0), 1);
        chk("key_valid1", 32'(kv1), 1);
        chk("key_idle_st0", 32'(st0), 0);
        chk("idle_ready0", 32'(rdy0), 1);

        // Round-robin, all ready: three packets
        for (int d = 0; d < 2; d++) begin
            push_ev(d, 1'b0, 0, 8'h10, 4'd0);
            push_ev(d, 1'b0, 1, 8'h32, 4'd1);
            push_ev(d, 1'b0, 2, 8'h54, 4'd2);
        end
        for (int i = 0; i < 6; i++) bq.push_back(4'(i));
        send_burst();
        wait_idle();
        chk("rr_ptr0_s2", 32'(ptr0), 3);
        chk("count0_s2", 32'(cnt0), 3);
        chk("rr_ptr1_s2", 32'(ptr1), 3);
        chk("count1_s2", 32'(cnt1), 3);

        // Channel 1 busy: round-robin stalls, first-ready picks channel 2
        enc_ready = 4'b1101;
        push_ev(0, 1'b0, 0, 8'h21, 4'd0);
        push_ev(0, 1'b0, 1, 8'h43, 4'd1);
        push_ev(1, 1'b0, 0, 8'h21, 4'd0);
        push_ev(1, 1'b0, 2, 8'h43, 4'd1);
        bq.push_back(4'h1); bq.push_back(4'h2); bq.push_back(4'h3); bq.push_back(4'h4);
        send_burst();
        for (int i = 0; i < 10; i++) begin
            chk("stall_st0", 32'(st0), 6);
            chk("stall_ready0", 32'(rdy0), 0);
            if (i == 1) chk("first_ready_done_st1", 32'(st1), 0);
            @(negedge clk);
        end
        enc_ready = 4'hF;
        wait_idle();
        chk("rr_ptr0_s3", 32'(ptr0), 2);
        chk("count0_s3", 32'(cnt0), 2);
        chk("rr_ptr1_s3", 32'(ptr1), 3);
        chk("count1_s3", 32'(cnt1), 2);

        // 17 packets: rotation wraps 15 -> 0, pointer wraps every 4
        for (int k = 0; k < 17; k++) begin
            dv = {4'((2*k + 1) % 16), 4'((2*k) % 16)};
            push_ev(0, 1'b0, k % 4, dv, 4'(k % 16));
            push_ev(1, 1'b0, k % 4, dv, 4'(k % 16));
        end
        for (int i = 0; i < 34; i++) bq.push_back(4'(i % 16));
        send_burst();
        wait_idle();
        chk("rr_ptr0_s4", 32'(ptr0), 1);
        chk("count0_s4", 32'(cnt0), 17);
        chk("rr_ptr1_s4", 32'(ptr1), 1);
        chk("count1_s4", 32'(cnt1), 17);

        // Single-beat burst: padded on dut0, discarded on dut1
        push_ev(0, 1'b0, 0, 8'h07, 4'd0);
        bq.push_back(4'h7);
        send_burst();
        wait_idle();
        chk("pad_count0", 32'(cnt0), 1);
        chk("pad_ptr0", 32'(ptr0), 1);
        chk("discard_count1", 32'(cnt1), 0);
        chk("discard_ptr1", 32'(ptr1), 0);

        // Reset while waiting in DISPATCH
        enc_ready = 4'h0;
        bq.push_back(4'h1); bq.push_back(4'h2);
        send_burst();
        chk("disp_wait_st0", 32'(st0), 6);
        chk("disp_wait_st1", 32'(st1), 6);
        reset = 1'b1;
        @(negedge clk);
        chk_both_zero();
        reset = 1'b0;
        enc_ready = 4'hF;
        qspi_sending = 1'b1;
        qspi_data = 4'h9;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_ready0", 32'(rdy0), 0);
            chk("post_rst_ready1", 32'(rdy1), 0);
            chk("post_rst_st0", 32'(st0), 0);
        end
        qspi_sending = 1'b0;

        // Reset during LOAD: only the first key word reaches the encrypters
        @(negedge clk); prog = 1'b1;
        @(negedge clk); prog = 1'b0;
        push_ev(0, 1'b1, 0, 8'h21, 4'h0);
        push_ev(1, 1'b1, 0, 8'h21, 4'h0);
        bq.push_back(4'h1); bq.push_back(4'h2); bq.push_back(4'h3); bq.push_back(4'h4);
        send_burst();
        chk("load_st0", 32'(st0), 3);
        reset = 1'b1;
        @(negedge clk);
        chk_both_zero();
        reset = 1'b0;
        qspi_sending = 1'b1;
        @(negedge clk);
        chk("post_load_rst_ready0", 32'(rdy0), 0);
        chk("post_load_rst_ready1", 32'(rdy1), 0);
        qspi_sending = 1'b0;

        repeat (2) @(negedge clk);
        chk("sb0_drain", 32'(q0.size()), 0);
        chk("sb1_drain", 32'(q1.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
